// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: shared constants, state encoding and counter sizing for the accumulate stage
package prod_accum_pkg;
  localparam int PROD_W = 4;
  typedef enum logic {ACC, HOLD} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/prod_accum_if.sv
// prod_accum_if: product input and frame result valid/ready handshakes
interface prod_accum_if
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  sum;
  logic              ovf;
  modport master (output in_valid, prod, out_ready, input in_ready, out_valid, sum, ovf);
  modport slave  (input in_valid, prod, out_ready, output in_ready, out_valid, sum, ovf);
endinterface

// File: rtl/prod_accum.sv
// prod_accum: sums fixed-length frames of N products and presents the total with a carry flag
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  prod_accum_if.slave  bus
);
  localparam int CW = cnt_w(N);
  if (N < 1 || N > 255) begin : g_bad_n
    $error("prod_accum: N out of range 1..255");
  end
  if (ACC_W < 4 || ACC_W > 32) begin : g_bad_w
    $error("prod_accum: ACC_W out of range 4..32");
  end
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] prod_x;
  logic [ACC_W:0]   add;
  logic             last;
  assign prod_x        = ACC_W'(bus.prod);
  assign add           = {1'b0, acc_q} + {1'b0, prod_x};
  assign last          = cnt_q == CW'(N - 1);
  assign bus.in_ready  = state_q == ACC || bus.out_ready;
  assign bus.out_valid = state_q == HOLD;
  assign bus.sum       = acc_q;
  assign bus.ovf       = ovf_q;
  // Next state: clr wins; in HOLD a draining result may overlap the next frame's first product
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == ACC) begin
      if (bus.in_valid) begin
        acc_d   = add[ACC_W-1:0];
        ovf_d   = ovf_q | add[ACC_W];
        cnt_d   = last ? '0 : cnt_q + CW'(1);
        state_d = last ? HOLD : ACC;
      end
    end else if (bus.out_ready) begin
      acc_d   = bus.in_valid ? prod_x : '0;
      ovf_d   = 1'b0;
      cnt_d   = (bus.in_valid && N > 1) ? CW'(1) : '0;
      state_d = (bus.in_valid && N == 1) ? HOLD : ACC;
    end
  end
  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed frames against N=4, N=32 and N=1 instances with result scoreboards
module tb_prod_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;
  prod_accum_if #(.ACC_W(8)) a ();
  prod_accum_if #(.ACC_W(8)) b ();
  prod_accum_if #(.ACC_W(8)) c ();
  prod_accum #(.N(4),  .ACC_W(8)) u4  (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(a));
  prod_accum #(.N(32), .ACC_W(8)) u32 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(b));
  prod_accum #(.N(1),  .ACC_W(8)) u1  (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(c));
  int checks = 0;
  int errors = 0;
  logic [8:0] qa[$], qb[$], qc[$];
  logic [8:0] ea, eb, ec;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic feed_a(input logic [3:0] p);
    a.in_valid = 1'b1;
    a.prod = p;
    step();
  endtask
  task automatic feed_b(input logic [3:0] p);
    b.in_valid = 1'b1;
    b.prod = p;
    step();
  endtask
  // Result monitors: every output handshake pops the oldest expected {ovf,sum}
  always @(negedge clk) if (rst_n && !clr && a.out_valid && a.out_ready) begin
    ea = (qa.size() != 0) ? qa.pop_front() : 'x;
    chk("a_res", {a.ovf, a.sum}, ea);
  end
  always @(negedge clk) if (rst_n && !clr && b.out_valid && b.out_ready) begin
    eb = (qb.size() != 0) ? qb.pop_front() : 'x;
    chk("b_res", {b.ovf, b.sum}, eb);
  end
  always @(negedge clk) if (rst_n && !clr && c.out_valid && c.out_ready) begin
    ec = (qc.size() != 0) ? qc.pop_front() : 'x;
    chk("c_res", {c.ovf, c.sum}, ec);
  end
  initial begin
    #100000;
    $display("FAIL watchdog checks %0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    a.in_valid = 0; a.prod = 0; a.out_ready = 0;
    b.in_valid = 0; b.prod = 0; b.out_ready = 0;
    c.in_valid = 0; c.prod = 0; c.out_ready = 0;
    #12;
    chk("rst_in_ready", a.in_ready, 1);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_sum", a.sum, 0);
    chk("rst_ovf", a.ovf, 0);
    rst_n = 1'b1;
    step();
    a.out_ready = 1'b1;
    qa.push_back({1'b0, 8'd20});
    feed_a(3); feed_a(6); feed_a(9); feed_a(2);
    a.in_valid = 1'b0;
    chk("t1_valid", a.out_valid, 1);
    step();
    chk("t1_pulse", a.out_valid, 0);
    a.out_ready = 1'b0;
    qa.push_back({1'b0, 8'd20});
    feed_a(3); feed_a(6); feed_a(9); feed_a(2);
    a.in_valid = 1'b0;
    repeat (5) begin
      chk("t2_in_ready", a.in_ready, 0);
      chk("t2_sum", a.sum, 20);
      step();
    end
    a.in_valid = 1'b1;
    a.prod = 9;
    a.out_ready = 1'b1;
    qa.push_back({1'b0, 8'd12});
    step();
    chk("t2_restart", a.sum, 9);
    chk("t2_restart_valid", a.out_valid, 0);
    feed_a(1); feed_a(1); feed_a(1);
    a.in_valid = 1'b0;
    step();
    feed_a(5); feed_a(5);
    a.prod = 5;
    clr = 1'b1;
    step();
    clr = 1'b0;
    a.in_valid = 1'b0;
    chk("t3_clr_sum", a.sum, 0);
    chk("t3_clr_valid", a.out_valid, 0);
    qa.push_back({1'b0, 8'd4});
    feed_a(1); feed_a(1); feed_a(1); feed_a(1);
    a.in_valid = 1'b0;
    step();
    feed_a(9); feed_a(9);
    a.in_valid = 1'b0;
    chk("t4_mid", a.sum, 18);
    #3 rst_n = 1'b0;
    #1;
    chk("t4_rst_sum", a.sum, 0);
    chk("t4_rst_in_ready", a.in_ready, 1);
    chk("t4_rst_valid", a.out_valid, 0);
    chk("t4_rst_ovf", a.ovf, 0);
    #2 rst_n = 1'b1;
    step();
    qa.push_back({1'b0, 8'd36});
    feed_a(9); feed_a(9); feed_a(9); feed_a(9);
    a.in_valid = 1'b0;
    step();
    b.out_ready = 1'b1;
    qb.push_back({1'b1, 8'd32});
    qb.push_back({1'b0, 8'd32});
    repeat (32) feed_b(9);
    chk("b_hold_ovf", b.ovf, 1);
    chk("b_hold_sum", b.sum, 32);
    feed_b(1);
    chk("b_new_ovf", b.ovf, 0);
    chk("b_new_sum", b.sum, 1);
    repeat (31) feed_b(1);
    b.in_valid = 1'b0;
    step();
    c.out_ready = 1'b1;
    qc.push_back({1'b0, 8'd1});
    qc.push_back({1'b0, 8'd2});
    qc.push_back({1'b0, 8'd3});
    for (int i = 1; i <= 3; i++) begin
      c.in_valid = 1'b1;
      c.prod = 4'(i);
      step();
      chk("c_valid", c.out_valid, 1);
      chk("c_sum", c.sum, i);
    end
    c.in_valid = 1'b0;
    step();
    chk("c_end_valid", c.out_valid, 0);
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    chk("qc_empty", qc.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
